// File: rtl/cpu_run_pkg.sv
// Shared types and helpers for the MIPS core run controller.
package cpu_run_pkg;

  // Controller states; the encoding is fixed so it can be read back on chip.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  // Increment val by inc (0 or 1) while saturating at the all-ones value
  // of a width-bit counter. Works on a 64-bit carrier so any counter width
  // up to 64 can share it; callers truncate the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic        inc,
                                          input int          width);
    logic [63:0] lim;
    if (width >= 64) begin
      lim = {64{1'b1}};
    end else begin
      lim = (64'd1 << width) - 64'd1;
    end
    if (!inc) begin
      sat_inc = val;
    end else if (val >= lim) begin
      sat_inc = lim;
    end else begin
      sat_inc = val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/cpu_run_if.sv
// Handshake and result bundle between a bench/host and the run controller.
interface cpu_run_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic [PC_W-1:0]  pc;
  logic             instr_retire;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic [PC_W-1:0]  halt_pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  // Host side: issues requests, observes the core PC/retire and results.
  modport master (
    output start, abort, pc, instr_retire,
    input  cpu_reset, running, done, timeout, halt_pc, cycle_cnt, instr_cnt
  );

  // Controller side.
  modport slave (
    input  start, abort, pc, instr_retire,
    output cpu_reset, running, done, timeout, halt_pc, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/cpu_halt_detect.sv
// Detects a halted core: the fetch PC stays unchanged for HALT_STALL
// consecutive RUN cycles. The first enabled cycle has no valid previous PC.
module cpu_halt_detect #(
  parameter int PC_W       = 32,
  parameter int HALT_STALL = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            halt_o
);

  localparam int STALL_W = (HALT_STALL > 2) ? $clog2(HALT_STALL) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(HALT_STALL - 1);

  logic [PC_W-1:0]    prev_pc_q, prev_pc_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               valid_q, valid_d;
  logic               same_s;

  // Track previous PC and the run of unchanged-PC cycles while enabled.
  always_comb begin
    prev_pc_d = prev_pc_q;
    stall_d   = stall_q;
    valid_d   = valid_q;
    same_s    = valid_q && (pc_i == prev_pc_q);
    if (en_i) begin
      prev_pc_d = pc_i;
      valid_d   = 1'b1;
      if (same_s) begin
        stall_d = (stall_q == STALL_LAST) ? stall_q : stall_q + STALL_W'(1);
      end else begin
        stall_d = '0;
      end
    end else begin
      valid_d = 1'b0;
      stall_d = '0;
    end
    halt_o = en_i && same_s && (stall_q == STALL_LAST);
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc_q <= '0;
      stall_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      prev_pc_q <= prev_pc_d;
      stall_q   <= stall_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the core in reset, runs it, counts cycles and
// retired instructions, and stops on halt, timeout or abort.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST_HOLD   = 4,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int HALT_STALL = 8,
  parameter int MAX_CYCLES = 100000
) (
  input  logic     clk,
  input  logic     reset,
  cpu_run_if.slave run
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CYCLES);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic              timeout_q, timeout_d;
  logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
  logic              cpu_reset_q, running_q, done_q;
  logic              in_run_s;
  logic              halt_s;

  assign in_run_s = (state_q == ST_RUN);

  cpu_halt_detect #(
    .PC_W       (PC_W),
    .HALT_STALL (HALT_STALL)
  ) u_halt (
    .clk    (clk),
    .reset  (reset),
    .en_i   (in_run_s),
    .pc_i   (run.pc),
    .halt_o (halt_s)
  );

  // Next-state and result update; abort always wins over start.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    timeout_d = timeout_q;
    halt_pc_d = halt_pc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run.abort) begin
          state_d = ST_IDLE;
        end else if (run.start) begin
          state_d   = ST_HOLD;
          hold_d    = HOLD_LOAD;
          cycle_d   = '0;
          instr_d   = '0;
          timeout_d = 1'b0;
          halt_pc_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (run.abort) begin
          state_d = ST_IDLE;
        end else if (hold_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cycle_d = CNT_W'(sat_inc(64'(cycle_q), 1'b1, CNT_W));
        instr_d = CNT_W'(sat_inc(64'(instr_q), run.instr_retire, CNT_W));
        if (run.abort) begin
          state_d = ST_IDLE;
        end else if (halt_s) begin
          state_d   = ST_DONE;
          halt_pc_d = run.pc;
          timeout_d = 1'b0;
        end else if ((MAX_CYCLES != 0) && (cycle_d == MAX_C)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      timeout_q   <= 1'b0;
      halt_pc_q   <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      timeout_q   <= timeout_d;
      halt_pc_q   <= halt_pc_d;
      cpu_reset_q <= (state_d != ST_RUN);
      running_q   <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign run.cpu_reset = cpu_reset_q;
  assign run.running   = running_q;
  assign run.done      = done_q;
  assign run.timeout   = timeout_q;
  assign run.halt_pc   = halt_pc_q;
  assign run.cycle_cnt = cycle_q;
  assign run.instr_cnt = instr_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized and directed bench for cpu_run_ctrl against a run-level model.
module tb_cpu_run_ctrl;

  localparam int PC_W       = 32;
  localparam int CNT_W      = 32;
  localparam int RST_HOLD   = 4;
  localparam int HALT_STALL = 8;
  localparam int MAX_CYCLES = 50;

  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_run_if #(.PC_W(PC_W), .CNT_W(CNT_W)) run_if ();

  cpu_run_ctrl #(
    .RST_HOLD   (RST_HOLD),
    .PC_W       (PC_W),
    .CNT_W      (CNT_W),
    .HALT_STALL (HALT_STALL),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run_if)
  );

  int errors = 0;
  int checks = 0;

  // Run-level model: phase, cycles spent in hold, the recent PC history of
  // the current run, and the visible results.
  int               m_phase;
  int               m_hold_seen;
  logic [PC_W-1:0]  m_pcs[$];
  logic [CNT_W-1:0] m_cyc;
  logic [CNT_W-1:0] m_ins;
  logic             m_tmo;
  logic [PC_W-1:0]  m_hpc;

  logic [PC_W-1:0]  cur_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] msat(input logic [CNT_W-1:0] v, input logic inc);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(inc);
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    m_hold_seen = 0;
    m_pcs.delete();
    m_cyc = '0;
    m_ins = '0;
    m_tmo = 1'b0;
    m_hpc = '0;
  endtask

  task automatic model_step(input logic st, input logic ab, input logic [PC_W-1:0] p, input logic r);
    bit halted;
    case (m_phase)
      M_IDLE, M_DONE: begin
        if (ab) m_phase = M_IDLE;
        else if (st) begin
          m_phase = M_HOLD; m_hold_seen = 0;
          m_cyc = '0; m_ins = '0; m_tmo = 1'b0; m_hpc = '0;
        end
      end
      M_HOLD: begin
        if (ab) m_phase = M_IDLE;
        else begin
          m_hold_seen++;
          if (m_hold_seen == RST_HOLD) begin
            m_phase = M_RUN;
            m_pcs.delete();
          end
        end
      end
      default: begin
        m_cyc = msat(m_cyc, 1'b1);
        m_ins = msat(m_ins, r);
        m_pcs.push_back(p);
        if (m_pcs.size() > HALT_STALL + 1) void'(m_pcs.pop_front());
        // Halted when the PC was unchanged across HALT_STALL successive cycles.
        halted = (m_pcs.size() == HALT_STALL + 1);
        foreach (m_pcs[k]) if (m_pcs[k] != p) halted = 1'b0;
        if (ab) m_phase = M_IDLE;
        else if (halted) begin
          m_phase = M_DONE; m_hpc = p; m_tmo = 1'b0;
        end else if (MAX_CYCLES != 0 && m_cyc == CNT_W'(MAX_CYCLES)) begin
          m_phase = M_DONE; m_tmo = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cpu_reset"}, 64'(run_if.cpu_reset), 64'(m_phase != M_RUN));
    chk({tag, ".running"},   64'(run_if.running),   64'(m_phase == M_RUN));
    chk({tag, ".done"},      64'(run_if.done),      64'(m_phase == M_DONE));
    chk({tag, ".timeout"},   64'(run_if.timeout),   64'(m_tmo));
    chk({tag, ".halt_pc"},   64'(run_if.halt_pc),   64'(m_hpc));
    chk({tag, ".cycle_cnt"}, 64'(run_if.cycle_cnt), 64'(m_cyc));
    chk({tag, ".instr_cnt"}, 64'(run_if.instr_cnt), 64'(m_ins));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input string tag, input logic st, input logic ab,
                      input logic [PC_W-1:0] p, input logic r);
    run_if.start = st;
    run_if.abort = ab;
    run_if.pc = p;
    run_if.instr_retire = r;
    model_step(st, ab, p, r);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Start from IDLE/DONE and measure how many sampled cycles cpu_reset stays high.
  task automatic start_and_hold(input string tag);
    int n;
    step(tag, 1'b1, 1'b0, cur_pc, 1'b0);
    n = 0;
    while (run_if.cpu_reset && n < 12) begin
      n++;
      step(tag, 1'b0, 1'b0, cur_pc, 1'b0);
    end
    chk({tag, ".hold_len"}, 64'(n), 64'(RST_HOLD));
  endtask

  logic [PC_W-1:0] base;
  logic            frz;
  int              frz_left;

  initial begin
    reset = 1'b0;
    run_if.start = 1'b0;
    run_if.abort = 1'b0;
    run_if.pc = '0;
    run_if.instr_retire = 1'b0;
    cur_pc = 32'h0000_1000;
    model_reset();

    // 1: reset for three cycles, then start at cycle 5.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    step("idle", 1'b0, 1'b0, cur_pc, 1'b0);
    start_and_hold("t1");
    chk("t1.running", 64'(run_if.running), 64'd1);

    // 2: 20 retiring cycles with PC +4, then frozen at 0x3010 -> halt.
    base = 32'h0000_3010 - 32'd76;
    for (int i = 0; i < 20; i++) step("t2", 1'b0, 1'b0, base + PC_W'(4 * i), 1'b1);
    for (int i = 0; i < 20 && !run_if.done; i++) step("t2", 1'b0, 1'b0, 32'h0000_3010, 1'b0);
    chk("t2.done", 64'(run_if.done), 64'd1);
    chk("t2.halt_pc", 64'(run_if.halt_pc), 64'h3010);
    chk("t2.instr", 64'(run_if.instr_cnt), 64'd20);
    chk("t2.cycles", 64'(run_if.cycle_cnt), 64'd28);
    chk("t2.timeout", 64'(run_if.timeout), 64'd0);

    // 3: restart from DONE, PC always moving -> timeout at MAX_CYCLES.
    cur_pc = 32'h0000_4000;
    start_and_hold("t3");
    for (int i = 0; i < 70 && !run_if.done; i++) begin
      cur_pc = cur_pc + 32'd4;
      step("t3", 1'b0, 1'b0, cur_pc, i[0]);
    end
    chk("t3.timeout", 64'(run_if.timeout), 64'd1);
    chk("t3.cycles", 64'(run_if.cycle_cnt), 64'(MAX_CYCLES));
    step("t3.after", 1'b0, 1'b0, cur_pc, 1'b0);
    chk("t3.cpu_reset", 64'(run_if.cpu_reset), 64'd1);

    // 4: halt detected on the same edge as the timeout -> halt wins.
    base = 32'h0000_8000;
    start_and_hold("t4");
    for (int c = 1; c <= 70 && !run_if.done; c++) begin
      cur_pc = (c < 42) ? base + PC_W'(4 * c) : base + PC_W'(4 * 42);
      step("t4", 1'b0, 1'b0, cur_pc, 1'b1);
    end
    chk("t4.timeout", 64'(run_if.timeout), 64'd0);
    chk("t4.cycles", 64'(run_if.cycle_cnt), 64'(MAX_CYCLES));
    chk("t4.halt_pc", 64'(run_if.halt_pc), 64'(base + PC_W'(4 * 42)));

    // 5: abort in RUN cycle 10, later a full run and a restart from DONE.
    start_and_hold("t5");
    for (int c = 1; c <= 10; c++) begin
      cur_pc = cur_pc + 32'd4;
      step("t5", 1'b0, (c == 10), cur_pc, 1'b1);
    end
    chk("t5.cycles", 64'(run_if.cycle_cnt), 64'd10);
    chk("t5.done", 64'(run_if.done), 64'd0);
    start_and_hold("t5b");
    for (int i = 0; i < 70 && !run_if.done; i++) begin
      cur_pc = cur_pc + 32'd4;
      step("t5b", 1'b0, 1'b0, cur_pc, 1'b0);
    end
    start_and_hold("t5c");
    chk("t5c.cycles", 64'(run_if.cycle_cnt), 64'd0);

    // 6: asynchronous reset mid-run, then start+abort together in IDLE.
    for (int i = 0; i < 5; i++) begin
      cur_pc = cur_pc + 32'd4;
      step("t6", 1'b0, 1'b0, cur_pc, 1'b1);
    end
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    @(posedge clk);
    #2;
    reset = 1'b1;
    step("t6.both", 1'b1, 1'b1, cur_pc, 1'b0);
    chk("t6.idle", 64'(run_if.cpu_reset), 64'd1);
    step("t6.idle2", 1'b0, 1'b0, cur_pc, 1'b0);

    // Random traffic: sparse start/abort, PC that moves or freezes in bursts.
    frz = 1'b0;
    frz_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (frz_left == 0) begin
        frz = $urandom_range(0, 1) == 1;
        frz_left = $urandom_range(1, 12);
      end
      frz_left--;
      if (!frz) cur_pc = cur_pc + 32'd4;
      step("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
           cur_pc, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
